// File: rtl/swt16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : swt16_pkg
// Description : Shared constants and types for the swt16 data-memory path.
// Revision    : 1.0 - initial release
// ============================================================================
package swt16_pkg;

    localparam logic [0:0] ARB_ST_ARB    = 1'b0;
    localparam logic [0:0] ARB_ST_LOCKED = 1'b1;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

    typedef enum logic [0:0] {
        ST_ARB    = ARB_ST_ARB,
        ST_LOCKED = ARB_ST_LOCKED
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Core/debug arbiter for the single data-memory port, with
//               anti-starvation streak limit and debug burst lock.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import swt16_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int WORD_WIDTH = 16,
    parameter int MAX_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_core_req,
    input  logic                  in_core_we,
    input  logic [ADDR_WIDTH-1:0] in_core_addr,
    input  logic [WORD_WIDTH-1:0] in_core_wdata,
    output logic                  out_core_gnt,
    output logic                  out_core_stall,
    output logic                  out_core_rvalid,
    output logic [WORD_WIDTH-1:0] out_core_rdata,
    input  logic                  in_dbg_req,
    input  logic                  in_dbg_we,
    input  logic                  in_dbg_lock,
    input  logic [ADDR_WIDTH-1:0] in_dbg_addr,
    input  logic [WORD_WIDTH-1:0] in_dbg_wdata,
    output logic                  out_dbg_gnt,
    output logic                  out_dbg_rvalid,
    output logic [WORD_WIDTH-1:0] out_dbg_rdata,
    output logic [ADDR_WIDTH-1:0] out_mem_rd_addr,
    output logic [ADDR_WIDTH-1:0] out_mem_wr_addr,
    output logic [WORD_WIDTH-1:0] out_mem_wr_word,
    output logic                  out_mem_write_en,
    input  logic [WORD_WIDTH-1:0] in_mem_rd_word
);

    localparam int                  c_streak_w   = $clog2(MAX_STREAK + 1);
    localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(MAX_STREAK);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [c_streak_w-1:0]   r_streak;
    logic [c_streak_w-1:0]   w_streak_next;
    logic                    w_lock_hold;
    logic                    w_core_win;
    logic                    w_dbg_win;
    logic                    w_any_gnt;
    logic                    w_win_we;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [WORD_WIDTH-1:0]   w_win_wdata;
    logic                    w_rd_gnt;
    logic                    w_core_rvalid;
    logic                    w_dbg_rvalid;

    logic [ADDR_WIDTH-1:0]   r_addr_hold;
    logic [WORD_WIDTH-1:0]   r_word_hold;
    logic                    r_rd_pending;
    logic                    r_rd_owner;
    logic [WORD_WIDTH-1:0]   r_core_rdata;
    logic [WORD_WIDTH-1:0]   r_dbg_rdata;

    always_comb begin
        w_state_next  = r_state;
        w_streak_next = r_streak;
        w_core_win    = 1'b0;
        w_dbg_win     = 1'b0;
        w_lock_hold   = (r_state == ST_LOCKED) && in_dbg_lock;
        if (reset) begin
            w_state_next  = ST_ARB;
            w_streak_next = '0;
        end else if (w_lock_hold) begin
            w_dbg_win     = in_dbg_req;
            w_streak_next = '0;
        end else begin
            // A released lock falls through here and is arbitrated this same cycle.
            w_dbg_win    = in_dbg_req && (!in_core_req || (r_streak == c_streak_max));
            w_core_win   = in_core_req && !w_dbg_win;
            w_state_next = (w_dbg_win && in_dbg_lock) ? ST_LOCKED : ST_ARB;
            if (w_core_win && in_dbg_req) begin
                w_streak_next = (r_streak == c_streak_max) ? c_streak_max : r_streak + 1'b1;
            end else begin
                w_streak_next = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= ST_ARB;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_next;
            r_streak <= w_streak_next;
        end
    end

    assign w_any_gnt   = w_core_win || w_dbg_win;
    assign w_win_we    = w_dbg_win ? in_dbg_we    : in_core_we;
    assign w_win_addr  = w_dbg_win ? in_dbg_addr  : in_core_addr;
    assign w_win_wdata = w_dbg_win ? in_dbg_wdata : in_core_wdata;
    assign w_rd_gnt    = w_any_gnt && !w_win_we;

    assign out_core_gnt     = w_core_win;
    assign out_dbg_gnt      = w_dbg_win;
    assign out_core_stall   = in_core_req && !w_core_win;
    assign out_mem_write_en = w_any_gnt && w_win_we;

    // Idle cycles keep the last address/data on the port rather than glitching to the loser.
    assign out_mem_rd_addr = reset ? '0 : (w_any_gnt ? w_win_addr : r_addr_hold);
    assign out_mem_wr_addr = out_mem_rd_addr;
    assign out_mem_wr_word = reset ? '0 : (w_any_gnt ? w_win_wdata : r_word_hold);

    assign w_core_rvalid   = !reset && r_rd_pending && (r_rd_owner == REQ_CORE);
    assign w_dbg_rvalid    = !reset && r_rd_pending && (r_rd_owner == REQ_DBG);
    assign out_core_rvalid = w_core_rvalid;
    assign out_dbg_rvalid  = w_dbg_rvalid;
    assign out_core_rdata  = reset ? '0 : (w_core_rvalid ? in_mem_rd_word : r_core_rdata);
    assign out_dbg_rdata   = reset ? '0 : (w_dbg_rvalid  ? in_mem_rd_word : r_dbg_rdata);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr_hold  <= '0;
            r_word_hold  <= '0;
            r_rd_pending <= 1'b0;
            r_rd_owner   <= REQ_CORE;
            r_core_rdata <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            if (w_any_gnt) begin
                r_addr_hold <= w_win_addr;
                r_word_hold <= w_win_wdata;
            end
            r_rd_pending <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_owner <= w_dbg_win ? REQ_DBG : REQ_CORE;
            end
            if (w_core_rvalid) begin
                r_core_rdata <= in_mem_rd_word;
            end
            if (w_dbg_rvalid) begin
                r_dbg_rdata <= in_mem_rd_word;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Scoreboard bench for dmem_arbiter with a write-first dmem model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW = 12;
    localparam int WW = 16;
    localparam int MS = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_core_req, in_core_we;
    logic [AW-1:0] in_core_addr;
    logic [WW-1:0] in_core_wdata;
    logic          out_core_gnt, out_core_stall, out_core_rvalid;
    logic [WW-1:0] out_core_rdata;
    logic          in_dbg_req, in_dbg_we, in_dbg_lock;
    logic [AW-1:0] in_dbg_addr;
    logic [WW-1:0] in_dbg_wdata;
    logic          out_dbg_gnt, out_dbg_rvalid;
    logic [WW-1:0] out_dbg_rdata;
    logic [AW-1:0] out_mem_rd_addr, out_mem_wr_addr;
    logic [WW-1:0] out_mem_wr_word;
    logic          out_mem_write_en;
    logic [WW-1:0] in_mem_rd_word = '0;

    dmem_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .MAX_STREAK(MS)) dut (
        .clock(clock), .reset(reset),
        .in_core_req(in_core_req), .in_core_we(in_core_we),
        .in_core_addr(in_core_addr), .in_core_wdata(in_core_wdata),
        .out_core_gnt(out_core_gnt), .out_core_stall(out_core_stall),
        .out_core_rvalid(out_core_rvalid), .out_core_rdata(out_core_rdata),
        .in_dbg_req(in_dbg_req), .in_dbg_we(in_dbg_we), .in_dbg_lock(in_dbg_lock),
        .in_dbg_addr(in_dbg_addr), .in_dbg_wdata(in_dbg_wdata),
        .out_dbg_gnt(out_dbg_gnt), .out_dbg_rvalid(out_dbg_rvalid),
        .out_dbg_rdata(out_dbg_rdata),
        .out_mem_rd_addr(out_mem_rd_addr), .out_mem_wr_addr(out_mem_wr_addr),
        .out_mem_wr_word(out_mem_wr_word), .out_mem_write_en(out_mem_write_en),
        .in_mem_rd_word(in_mem_rd_word)
    );

    always #5 clock = ~clock;

    // Synchronous write-first data memory standing in for dmem_sim.
    logic [WW-1:0] dmem [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) dmem[i] = '0;
    always @(posedge clock) begin
        if (out_mem_write_en) dmem[out_mem_wr_addr] <= out_mem_wr_word;
        in_mem_rd_word <= (out_mem_write_en && out_mem_wr_addr == out_mem_rd_addr)
                          ? out_mem_wr_word : dmem[out_mem_rd_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int            cyc;
        logic [WW-1:0] data;
    } rd_t;
    rd_t core_q[$];
    rd_t dbg_q[$];

    // Reference model: grants from the priority/streak/lock rules, memory as a sparse array.
    logic [WW-1:0] ref_mem [int];
    int            m_streak = 0;
    bit            m_locked = 1'b0;
    int            m_addr   = 0;

    always @(negedge clock) begin
        bit  hold, e_cg, e_dg, e_we;
        int  e_addr, e_data;
        rd_t item;
        if (reset) begin
            check("rst_core_gnt", int'(out_core_gnt), 0);
            check("rst_dbg_gnt", int'(out_dbg_gnt), 0);
            check("rst_write_en", int'(out_mem_write_en), 0);
            check("rst_rd_addr", int'(out_mem_rd_addr), 0);
            check("rst_wr_word", int'(out_mem_wr_word), 0);
            m_streak = 0;
            m_locked = 1'b0;
            m_addr   = 0;
        end else begin
            hold = m_locked && in_dbg_lock;
            if (hold) begin
                e_dg = in_dbg_req;
                e_cg = 1'b0;
            end else begin
                e_dg = in_dbg_req && (!in_core_req || m_streak == MS);
                e_cg = in_core_req && !e_dg;
            end
            check("core_gnt", int'(out_core_gnt), int'(e_cg));
            check("dbg_gnt", int'(out_dbg_gnt), int'(e_dg));
            check("core_stall", int'(out_core_stall), int'(in_core_req && !e_cg));
            if (e_cg || e_dg) begin
                e_we   = e_dg ? in_dbg_we : in_core_we;
                e_addr = e_dg ? int'(in_dbg_addr) : int'(in_core_addr);
                e_data = e_dg ? int'(in_dbg_wdata) : int'(in_core_wdata);
                check("write_en", int'(out_mem_write_en), int'(e_we));
                check("rd_addr", int'(out_mem_rd_addr), e_addr);
                check("wr_addr", int'(out_mem_wr_addr), e_addr);
                if (e_we) begin
                    check("wr_word", int'(out_mem_wr_word), e_data);
                    ref_mem[e_addr] = WW'(e_data);
                end else begin
                    item.cyc  = cyc;
                    item.data = ref_mem.exists(e_addr) ? ref_mem[e_addr] : '0;
                    if (e_dg) dbg_q.push_back(item);
                    else      core_q.push_back(item);
                end
                m_addr = e_addr;
            end else begin
                check("idle_write_en", int'(out_mem_write_en), 0);
                check("idle_addr_hold", int'(out_mem_rd_addr), m_addr);
            end
            if (hold || e_dg)                 m_streak = 0;
            else if (e_cg && in_dbg_req)      m_streak = (m_streak + 1 > MS) ? MS : m_streak + 1;
            else                              m_streak = 0;
            m_locked = hold || (e_dg && in_dbg_lock);
        end
    end

    // Monitor: read data must appear exactly one cycle after its grant, on the right port.
    always @(negedge clock) begin
        rd_t r;
        if (reset) begin
            check("rst_core_rvalid", int'(out_core_rvalid), 0);
            check("rst_dbg_rvalid", int'(out_dbg_rvalid), 0);
            core_q.delete();
            dbg_q.delete();
        end else begin
            if (out_core_rvalid) begin
                if (core_q.size() == 0) check("core_rvalid_spurious", int'(out_core_rvalid), 0);
                else begin
                    r = core_q.pop_front();
                    check("core_rd_latency", cyc, r.cyc + 1);
                    check("core_rdata", int'(out_core_rdata), int'(r.data));
                end
            end else if (core_q.size() > 0 && core_q[0].cyc < cyc) begin
                check("core_rvalid_missing", int'(out_core_rvalid), 1);
                void'(core_q.pop_front());
            end
            if (out_dbg_rvalid) begin
                if (dbg_q.size() == 0) check("dbg_rvalid_spurious", int'(out_dbg_rvalid), 0);
                else begin
                    r = dbg_q.pop_front();
                    check("dbg_rd_latency", cyc, r.cyc + 1);
                    check("dbg_rdata", int'(out_dbg_rdata), int'(r.data));
                end
            end else if (dbg_q.size() > 0 && dbg_q[0].cyc < cyc) begin
                check("dbg_rvalid_missing", int'(out_dbg_rvalid), 1);
                void'(dbg_q.pop_front());
            end
        end
    end

    task automatic drive(input bit rst,
                         input bit cr, input bit cw, input int ca, input int cd,
                         input bit dr, input bit dw, input bit dl, input int da, input int dd);
        @(posedge clock);
        #1;
        reset         = rst;
        in_core_req   = cr;
        in_core_we    = cw;
        in_core_addr  = AW'(ca);
        in_core_wdata = WW'(cd);
        in_dbg_req    = dr;
        in_dbg_we     = dw;
        in_dbg_lock   = dl;
        in_dbg_addr   = AW'(da);
        in_dbg_wdata  = WW'(dd);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit lk;
        reset = 1'b1;
        in_core_req = 0; in_core_we = 0; in_core_addr = '0; in_core_wdata = '0;
        in_dbg_req = 0; in_dbg_we = 0; in_dbg_lock = 0; in_dbg_addr = '0; in_dbg_wdata = '0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Core read at 0x010 immediately followed by reset: the read must vanish.
        drive(0, 1, 0, 'h010, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Core-only write then read-back.
        drive(0, 1, 1, 'h020, 'h1234, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 'h020, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Full contention: expect C,C,C,C,D repeating.
        for (int i = 0; i < 15; i++)
            drive(0, 1, 0, 'h040 + i, 0, 1, (i % 3) == 0, 0, 'h080 + i, 'hD000 + i);
        idle(1);

        // Debug lock burst writing 0x100..0x105 while the core keeps asking.
        drive(0, 0, 0, 0, 0, 1, 1, 1, 'h100, 'hA000);
        for (int i = 1; i < 6; i++) drive(0, 1, 0, 'h020, 0, 1, 1, 1, 'h100 + i, 'hA000 + i);
        drive(0, 1, 0, 'h020, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 'h105, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Interleaved reads at 0x030 (core) and 0x031 (debug).
        drive(0, 1, 1, 'h030, 'h3030, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 1, 0, 'h031, 'h3131);
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) drive(0, 1, 0, 'h030, 0, 0, 0, 0, 0, 0);
            else            drive(0, 0, 0, 0, 0, 1, 0, 0, 'h031, 0);
        end
        idle(1);

        // Randomised traffic over a small address window.
        lk = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) lk = !lk;
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, lk,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
        end
        idle(3);
        @(negedge clock);
        check("core_q_drained", core_q.size(), 0);
        check("dbg_q_drained", dbg_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
